// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int WIDTH_DEF    = 64;
  localparam int NREGS_DEF    = 32;
  localparam int NREAD_DEF    = 2;
  localparam int ZERO_REG_DEF = 31;
  localparam int AW_DEF       = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]    reg_idx_t;
  typedef logic [WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a register busy, writeback clears it, and a
// running count of busy registers is kept by the per-cycle delta.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [AW-1:0]    set_idx_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_idx_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             set_s, clr_s, set_new_s, clr_old_s;

  // Next busy vector (set beats clear on the same index) and count delta.
  always_comb begin
    set_s     = set_i && (set_idx_i != ZIDX);
    clr_s     = clr_i && (clr_idx_i != ZIDX);
    // A set only counts if the bit was clear; a clear only counts if the bit
    // was set and is not being re-set by a new producer in the same cycle.
    set_new_s = set_s && !busy_q[set_idx_i];
    clr_old_s = clr_s && busy_q[clr_idx_i] && !(set_s && (set_idx_i == clr_idx_i));
    for (int i = 0; i < NREGS; i++) begin
      if (i == ZERO_REG) begin
        busy_d[i] = 1'b0;
      end else if (set_s && (set_idx_i == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_s && (clr_idx_i == AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    case ({set_new_s, clr_old_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Busy bits and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired zero register, write-through
// bypass on every read port and an integrated busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RegWrite,
  input  logic [AW-1:0]               WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic                        IssueValid,
  input  logic [AW-1:0]               IssueRegister,
  input  logic [NREAD-1:0][AW-1:0]    ReadRegister,
  output logic [NREAD-1:0][WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]            ReadBusy,
  output logic [AW:0]                 BusyCount
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);

  logic                        we_s;
  logic [NREGS-1:0][WIDTH-1:0] store_s;
  logic [NREGS-1:0]            busy_s;

  assign we_s = RegWrite && (WriteRegister != ZIDX);

  // One storage register per architectural index; the zero register has none.
  for (genvar i = 0; i < NREGS; i++) begin : g_store
    if (i == ZERO_REG) begin : g_zero
      assign store_s[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q, data_d;

      // Load writeback data when this index is the destination.
      always_comb begin
        if (we_s && (WriteRegister == AW'(i))) begin
          data_d = WriteData;
        end else begin
          data_d = data_q;
        end
      end

      // Storage register, cleared asynchronously.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign store_s[i] = data_q;
    end
  end

  // Combinational read ports with zero-register override and same-cycle bypass.
  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic             byp_s;
    logic [WIDTH-1:0] rd_s;
    logic             rb_s;

    // Select zero, bypassed writeback data or stored value; mask busy on bypass.
    always_comb begin
      byp_s = RegWrite && (WriteRegister == ReadRegister[p]);
      if (ReadRegister[p] == ZIDX) begin
        rd_s = '0;
        rb_s = 1'b0;
      end else if (byp_s) begin
        rd_s = WriteData;
        rb_s = 1'b0;
      end else begin
        rd_s = store_s[ReadRegister[p]];
        rb_s = busy_s[ReadRegister[p]];
      end
    end

    assign ReadData[p] = rd_s;
    assign ReadBusy[p] = rb_s;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_i     (IssueValid),
    .set_idx_i (IssueRegister),
    .clr_i     (RegWrite),
    .clr_idx_i (WriteRegister),
    .busy_o    (busy_s),
    .count_o   (BusyCount)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an array-based model.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic            clk;
  logic            reset;
  logic            rw;
  reg_idx_t        wr;
  reg_data_t       wd;
  logic            iv;
  reg_idx_t        ir;
  logic [1:0][4:0]  rreg;
  logic [1:0][63:0] rdata;
  logic [1:0]       rbusy;
  logic [5:0]       bcount;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_mem  [32];
  bit          m_busy [32];

  regfile_sb dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (rw),
    .WriteRegister (wr),
    .WriteData     (wd),
    .IssueValid    (iv),
    .IssueRegister (ir),
    .ReadRegister  (rreg),
    .ReadData      (rdata),
    .ReadBusy      (rbusy),
    .BusyCount     (bcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 64'd0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [63:0] exp_data(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (rw && wr == idx) return wd;
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    if (idx == 5'd31) return 1'b0;
    if (rw && wr == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic drive(input logic rw_v, input logic [4:0] wr_v, input logic [63:0] wd_v,
                       input logic iv_v, input logic [4:0] ir_v,
                       input logic [4:0] r0, input logic [4:0] r1);
    rw = rw_v; wr = wr_v; wd = wd_v; iv = iv_v; ir = ir_v;
    rreg[0] = r0; rreg[1] = r1;
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic check_now();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rdata%0d_x%0d", p, rreg[p]), rdata[p], exp_data(rreg[p]));
      chk($sformatf("rbusy%0d_x%0d", p, rreg[p]), 64'(rbusy[p]), 64'(exp_busy(rreg[p])));
    end
    chk("busycount", 64'(bcount), 64'(exp_count()));
  endtask

  // Advance through the rising edge and apply the architectural effect.
  task automatic tick();
    @(posedge clk);
    if (rw && wr != 5'd31) begin
      m_mem[wr]  = wd;
      m_busy[wr] = 1'b0;
    end
    if (iv && ir != 5'd31) m_busy[ir] = 1'b1;
    #1;
  endtask

  function automatic logic [4:0] rnd_idx();
    int r = $urandom_range(0, 9);
    if (r == 0) return 5'd31;
    if (r < 6) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Reset state on every index of both ports
    for (int i = 0; i < 32; i++) begin
      rreg[0] = 5'(i);
      rreg[1] = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd0_x%0d", i), rdata[0], 64'd0);
      chk($sformatf("rst_rd1_x%0d", 31 - i), rdata[1], 64'd0);
      chk("rst_busy", 64'(rbusy), 64'd0);
    end
    chk("rst_count", 64'(bcount), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Bypass then storage read of X5
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 5'd5, 5'd5);
    check_now();
    chk("x5_bypass", rdata[0], 64'hDEAD_BEEF_0000_0001);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd6);
    check_now();
    chk("x5_stored", rdata[0], 64'hDEAD_BEEF_0000_0001);
    tick();

    // Zero register ignores writes and issues
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd31, 5'd31);
    check_now();
    chk("x31_write_bypass", rdata[0], 64'd0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd31, 5'd31);
    check_now();
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd5);
    check_now();
    chk("x31_read", rdata[0], 64'd0);
    chk("x31_busy", 64'(rbusy[0]), 64'd0);
    chk("x31_count", 64'(bcount), 64'd0);
    tick();

    // Issue X3, X7; writeback X3 resolves the hazard
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd7);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd3, 5'd7);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd7);
    check_now();
    chk("x3x7_count", 64'(bcount), 64'd2);
    chk("x3_busy", 64'(rbusy[0]), 64'd1);
    tick();
    drive(1'b1, 5'd3, 64'h42, 1'b0, 5'd0, 5'd3, 5'd7);
    check_now();
    chk("x3_wb_busy", 64'(rbusy[0]), 64'd0);
    chk("x3_wb_data", rdata[0], 64'h42);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd7);
    check_now();
    chk("x3_after_count", 64'(bcount), 64'd1);
    tick();

    // Same-cycle issue and write to a busy X9
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd7);
    check_now(); tick();
    drive(1'b1, 5'd9, 64'h1234, 1'b1, 5'd9, 5'd9, 5'd7);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd7);
    check_now();
    chk("x9_busy", 64'(rbusy[0]), 64'd1);
    chk("x9_count", 64'(bcount), 64'd2);
    tick();

    // Asynchronous reset in the middle of a cycle
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 5'd1, 5'd2);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 5'd1, 5'd2);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd1, 5'd4);
    check_now(); tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd9);
    chk("pre_arst_count", 64'(bcount), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("arst_count", 64'(bcount), 64'd0);
    chk("arst_x3", rdata[0], 64'd0);
    chk("arst_busy", 64'(rbusy), 64'd0);
    #1;
    reset = 1'b0;
    check_now(); tick();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] w_v, r0_v;
      w_v  = rnd_idx();
      r0_v = ($urandom_range(0, 3) == 0) ? w_v : rnd_idx();
      drive(1'($urandom_range(0, 1)), w_v, {$urandom, $urandom},
            1'($urandom_range(0, 1)), rnd_idx(), r0_v, rnd_idx());
      check_now();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
